exp_1x1_ker_read_cont: RTL
==========================

// Module: exp_1x1_ker_read_cont
// PURPOSE
//  Read-side controller for the expand 1x1 kernel RAM. Streams kernel words per input-depth layer
//  to the expand 1x1 compute array, once per output position (pass). A layer is read only after the
//  write controller reports it loaded via exp_1x1_layer_ready_no_i; later passes reuse resident kernels.
// PARAMETERS
//  ADDR_W  12  kernel RAM address width
//  DATA_W  32  kernel RAM word width
//  RD_LAT  2   RAM read latency, cycles from ram_rd_en_o to valid ram_rd_data_i (1..4)
// PORTS
//  clk_i                     in   1       system clock
//  rst_i                     in   1       asynchronous reset, active-high
//  start_i                   in   1       1-cycle pulse: load config, begin new fire layer
//  exp_1x1_en_i              in   1       expand 1x1 path enabled for this fire layer
//  one_exp1_ker_addr_limit_i in   7       words per depth layer minus 1 (L)
//  depth_limit_i             in   7       depth layers minus 1 (D)
//  tot_pass_i                in   16      passes (output positions) minus 1 (P)
//  exp_1x1_layer_ready_no_i  in   7       count of layers fully written to RAM
//  ram_rd_addr_o             out  ADDR_W  kernel RAM read address
//  ram_rd_en_o               out  1       kernel RAM read strobe
//  ram_rd_data_i             in   DATA_W  kernel RAM read data
//  ker_ready_i               in   1       array can take a word RD_LAT cycles later
//  ker_data_o                out  DATA_W  kernel word to array
//  ker_valid_o               out  1       ker_data_o valid
//  ker_layer_last_o          out  1       with valid: last word of a depth layer
//  ker_pass_last_o           out  1       with valid: last word of a pass
//  done_o                    out  1       1-cycle pulse, all passes issued and drained
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters/base 0, valid pipeline cleared, all_loaded 0.
//  - Config registered on start_i; inputs ignored otherwise.
//  - FSM: IDLE -start_i&en-> WAIT; IDLE -start_i&~en-> DRAIN (done_o next cycle, no reads).
//    WAIT -layer_ok-> READ. READ: issue per cycle when ker_ready_i; on last word of layer:
//    layer<D -> WAIT (layer+1); layer==D & pass<P -> WAIT (layer 0, pass+1); else DRAIN.
//    DRAIN -pipeline empty-> IDLE, done_o=1 that cycle.
//  - layer_ok = all_loaded | (exp_1x1_layer_ready_no_i > layer). all_loaded sets when
//    ready_no > D seen, or layer==D completes pass 0; covers ready_no wrap at D=127.
//  - Issue: ram_rd_en_o = (state==READ) & ker_ready_i; combinational addr = base + word.
//    word counts 0..L; base += L+1 on layer advance, base=0 at pass start. ADDR_W mod-2^ADDR_W add.
//  - ker_ready_i low in READ: hold addr/word, no strobe. No back-to-layer bubble required beyond 1 WAIT cycle.
//  - Data path: valid/last flags delayed RD_LAT cycles in shift register aligned with ram_rd_data_i;
//    ker_data_o = ram_rd_data_i combinationally, registered flags. Latency issue->valid = RD_LAT.
//  - start_i in any state: aborts, flushes pipeline (no stale valids), reloads config, no done_o.
//  - rst_i mid-stream: immediate clear; no partial word emitted after deassert.
//  - L=0 (1 word/layer): layer_last_o on every word. D=0,P=0: single word pass, both lasts set.
// TESTING
//  1. L=3,D=1,P=0, ready_no=2, ker_ready=1 -> addrs 0..7 consecutive, data RD_LAT later, layer_last on
//     words 3,7, pass_last on 7, done_o RD_LAT+1 cycles after last strobe.
//  2. L=1,D=2,P=1, ready_no steps 0->1->2->3 with gaps -> layer d never read before ready_no>d;
//     pass 1 addrs 0..5 issue without waiting.
//  3. L=3,D=0,P=2, ker_ready toggled 1010.. -> strobe only when ready, 12 words total, order 0..3 x3.
//  4. D=127,L=0,P=1, ready_no counts to 128 (wraps to 0) -> pass 1 proceeds, 256 words, addrs 0..127 twice.
//  5. start_i during READ of layer 1 -> no valid beyond in-flight flush, restart at addr 0, single done_o.
//  6. start_i with exp_1x1_en_i=0 -> zero strobes, done_o pulse; rst_i mid-pass -> outputs 0 same cycle.

Source files
------------

// File: rtl/exp_1x1_ker_read_cont.sv
`default_nettype none
// ============================================================================
//  Module   : exp_1x1_ker_read_cont
//  Purpose  : Read-side controller for the expand 1x1 kernel RAM; streams each
//             depth layer's kernel words once per output pass.
//  Revision : 1.0 - initial release
// ============================================================================
module exp_1x1_ker_read_cont #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              exp_1x1_en_i,
    input  logic [6:0]        one_exp1_ker_addr_limit_i,
    input  logic [6:0]        depth_limit_i,
    input  logic [15:0]       tot_pass_i,
    input  logic [6:0]        exp_1x1_layer_ready_no_i,
    output logic [ADDR_W-1:0] ram_rd_addr_o,
    output logic              ram_rd_en_o,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    input  logic              ker_ready_i,
    output logic [DATA_W-1:0] ker_data_o,
    output logic              ker_valid_o,
    output logic              ker_layer_last_o,
    output logic              ker_pass_last_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [6:0]          r_l;
    logic [6:0]          r_d;
    logic [15:0]         r_p;
    logic [6:0]          r_word;
    logic [6:0]          r_layer;
    logic [15:0]         r_pass;
    logic [ADDR_W-1:0]   r_base;
    logic                r_all_loaded;
    logic [6:0]          r_rdy_prev;
    logic [RD_LAT-1:0]   r_vld;
    logic [RD_LAT-1:0]   r_ll;
    logic [RD_LAT-1:0]   r_pl;
    logic                r_done;

    logic                w_issue;
    logic                w_word_last;
    logic                w_layer_last;
    logic                w_pass_last;
    logic                w_layer_ok;
    logic                w_rdy_wrap;
    logic                w_all_seen;
    logic [RD_LAT-1:0]   w_vld_nxt;
    logic [RD_LAT-1:0]   w_ll_nxt;
    logic [RD_LAT-1:0]   w_pl_nxt;

    assign w_issue      = (r_state == S_READ) & ker_ready_i;
    assign w_word_last  = (r_word == r_l);
    assign w_layer_last = (r_layer == r_d);
    assign w_pass_last  = (r_pass == r_p);

    // A 7-bit ready count cannot exceed 127, so with 128 layers the write side
    // signals completion by wrapping 127 -> 0.
    assign w_rdy_wrap   = (r_rdy_prev == 7'h7F) & (exp_1x1_layer_ready_no_i == 7'd0);
    assign w_all_seen   = (exp_1x1_layer_ready_no_i > r_d) | w_rdy_wrap;
    assign w_layer_ok   = r_all_loaded | (exp_1x1_layer_ready_no_i > r_layer);

    assign ram_rd_addr_o = r_base + ADDR_W'(r_word);
    assign ram_rd_en_o   = w_issue;

    // Flags travel alongside the RAM access so they line up with returning data.
    always_comb begin
        w_vld_nxt    = '0;
        w_ll_nxt     = '0;
        w_pl_nxt     = '0;
        w_vld_nxt[0] = w_issue;
        w_ll_nxt[0]  = w_issue & w_word_last;
        w_pl_nxt[0]  = w_issue & w_word_last & w_layer_last;
        for (int i = 1; i < RD_LAT; i++) begin
            w_vld_nxt[i] = r_vld[i-1];
            w_ll_nxt[i]  = r_ll[i-1];
            w_pl_nxt[i]  = r_pl[i-1];
        end
    end

    assign ker_valid_o      = r_vld[RD_LAT-1];
    assign ker_layer_last_o = r_ll[RD_LAT-1];
    assign ker_pass_last_o  = r_pl[RD_LAT-1];
    assign ker_data_o       = r_vld[RD_LAT-1] ? ram_rd_data_i : '0;
    assign done_o           = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_l          <= '0;
            r_d          <= '0;
            r_p          <= '0;
            r_word       <= '0;
            r_layer      <= '0;
            r_pass       <= '0;
            r_base       <= '0;
            r_all_loaded <= 1'b0;
            r_rdy_prev   <= '0;
            r_vld        <= '0;
            r_ll         <= '0;
            r_pl         <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rdy_prev <= exp_1x1_layer_ready_no_i;
            r_vld      <= w_vld_nxt;
            r_ll       <= w_ll_nxt;
            r_pl       <= w_pl_nxt;
            if (start_i) begin
                // Restart from any state: drop in-flight reads, no done pulse.
                r_l          <= one_exp1_ker_addr_limit_i;
                r_d          <= depth_limit_i;
                r_p          <= tot_pass_i;
                r_word       <= '0;
                r_layer      <= '0;
                r_pass       <= '0;
                r_base       <= '0;
                r_all_loaded <= 1'b0;
                r_vld        <= '0;
                r_ll         <= '0;
                r_pl         <= '0;
                r_state      <= exp_1x1_en_i ? S_WAIT : S_DRAIN;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_WAIT: begin
                        if (w_all_seen) r_all_loaded <= 1'b1;
                        if (w_layer_ok) r_state <= S_READ;
                    end
                    S_READ: begin
                        if (w_all_seen) r_all_loaded <= 1'b1;
                        if (ker_ready_i) begin
                            if (!w_word_last) begin
                                r_word <= r_word + 7'd1;
                            end else begin
                                r_word <= '0;
                                if (!w_layer_last) begin
                                    r_layer <= r_layer + 7'd1;
                                    r_base  <= r_base + ADDR_W'(r_l) + ADDR_W'(1);
                                    r_state <= S_WAIT;
                                end else if (!w_pass_last) begin
                                    // Every layer has now been read once, so it is resident.
                                    r_all_loaded <= 1'b1;
                                    r_layer      <= '0;
                                    r_pass       <= r_pass + 16'd1;
                                    r_base       <= '0;
                                    r_state      <= S_WAIT;
                                end else begin
                                    r_state <= S_DRAIN;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_vld_nxt == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
